scratch_port_arbiter: RTL and testbench

- Owns the single port of the 16-entry BPF scratch register file (M[]).
- Shares that port between three requesters:
  - stage2 reads (LDX/LD MEM), which have absolute priority and no backpressure.
  - stage1 writes (ST/STX), which are absorbed by a one-entry write buffer.
  - A debug/config port using valid/ready.
- Replaces the stage1 "write vs stage2 read" structural stall with a narrower write-ready condition.
- Forwards buffered data to younger reads.

---
 rtl/scratch_port_arbiter_pkg.sv | 25 ++
 rtl/scratch_port_arbiter_if.sv | 56 +++++
 rtl/scratch_port_arbiter_wbuf.sv | 75 +++++++
 rtl/scratch_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_scratch_port_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scratch_port_arbiter_pkg.sv
// Shared scratch-port constants, port-owner encodings and regfile source selects.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package scratch_port_arbiter_pkg;

    // Scratch register file geometry (M[0..15], 32-bit words)
    localparam int SCR_ADDR_WIDTH   = 4;
    localparam int SCR_DATA_WIDTH   = 32;
    localparam int SCR_STARVE_LIMIT = 8;
    localparam int SCR_CNT_WIDTH    = 4;

    // Stage1 write-data source select (regfile_sel): A or X
    localparam logic REGFILE_IN_A = 1'b0;
    localparam logic REGFILE_IN_X = 1'b1;

    // Who owns the single scratch memory port in a given cycle
    typedef enum logic [2:0] {
        OWN_NONE = 3'd0,
        OWN_RD   = 3'd1,
        OWN_BUF  = 3'd2,
        OWN_WR   = 3'd3,
        OWN_DBG  = 3'd4
    } port_own_e;

endpackage

// File: rtl/scratch_port_arbiter_if.sv
// Bundles the stage2 read, stage1 write, debug and scratch-memory signals.
// Latency: n/a (wires only).
// Backpressure: wr_rdy for stage1 writes, dbg_vld/dbg_rdy for debug; reads never stall.
interface scratch_port_arbiter_if
    import scratch_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = SCR_ADDR_WIDTH,
    parameter int DATA_WIDTH = SCR_DATA_WIDTH
);

    // Stage2 read
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_vld;

    // Stage1 write
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_rdy;

    // Debug / config port
    logic                  dbg_vld;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_rdy;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dbg_rdata_vld;
    logic                  hold_req;

    // Scratch memory port
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  dbg_vld, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
        output rd_data, rd_data_vld, wr_rdy, dbg_rdy, dbg_rdata, dbg_rdata_vld,
        output hold_req, mem_en, mem_we, mem_addr, mem_wdata
    );

    // Pipeline / debug / memory side
    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output dbg_vld, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
        input  rd_data, rd_data_vld, wr_rdy, dbg_rdy, dbg_rdata, dbg_rdata_vld,
        input  hold_req, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/scratch_port_arbiter_wbuf.sv
// One-entry stage1 write buffer with address-match forwarding to stage2 reads.
// Latency: load/commit take effect at the next edge; forwarded data appears with the 1-cycle read.
// Backpressure: none internally; the parent withholds i_load while the buffer cannot drain.
module scratch_port_arbiter_wbuf
    import scratch_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = SCR_ADDR_WIDTH,
    parameter int DATA_WIDTH = SCR_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_commit,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_buf_vld,
    output logic [ADDR_WIDTH-1:0] o_buf_addr,
    output logic [DATA_WIDTH-1:0] o_buf_data,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic                  r_buf_vld;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic                  r_fwd_q;
    logic [DATA_WIDTH-1:0] r_fwd_data;
    logic                  w_fwd_hit;

    // Only an already-buffered (older) write can forward; a same-cycle wr_en is younger.
    assign w_fwd_hit = i_rd_en && r_buf_vld && (i_rd_addr == r_buf_addr);

    // Buffer occupancy: a load wins over a commit so commit+replace keeps the entry full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_vld <= 1'b0;
        end else if (i_load) begin
            r_buf_vld <= 1'b1;
        end else if (i_commit) begin
            r_buf_vld <= 1'b0;
        end
    end

    // Buffer payload; only meaningful while r_buf_vld is set.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_buf_addr <= i_wr_addr;
            r_buf_data <= i_wr_data;
        end
    end

    // Forward select flag travels alongside the 1-cycle memory read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_q <= 1'b0;
        end else begin
            r_fwd_q <= w_fwd_hit;
        end
    end

    // Forwarded word captured at the read cycle.
    always_ff @(posedge clk) begin
        if (w_fwd_hit) begin
            r_fwd_data <= r_buf_data;
        end
    end

    assign o_buf_vld  = r_buf_vld;
    assign o_buf_addr = r_buf_addr;
    assign o_buf_data = r_buf_data;
    assign o_rd_data  = r_fwd_q ? r_fwd_data : i_mem_rdata;

endmodule

// File: rtl/scratch_port_arbiter.sv
// Arbitrates the single scratch memory port between stage2 reads, buffered stage1 writes and debug.
// Latency: reads and debug reads return one cycle after the access; writes commit same cycle or from the buffer.
// Backpressure: reads never stall; wr_rdy drops only with a full buffer and a read; debug waits, then raises hold_req.
module scratch_port_arbiter
    import scratch_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = SCR_ADDR_WIDTH,
    parameter int DATA_WIDTH   = SCR_DATA_WIDTH,
    parameter int STARVE_LIMIT = SCR_STARVE_LIMIT,
    parameter int CNT_WIDTH    = SCR_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    scratch_port_arbiter_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_HOLD  = CNT_WIDTH'(STARVE_LIMIT - 1);

    port_own_e             w_owner;
    logic                  w_buf_vld;
    logic [ADDR_WIDTH-1:0] w_buf_addr;
    logic [DATA_WIDTH-1:0] w_buf_data;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_buf_load;
    logic                  w_buf_commit;
    logic                  w_wr_rdy;
    logic                  w_dbg_rdy;
    logic                  w_dbg_grant;
    logic                  w_dbg_wait;
    logic [CNT_WIDTH-1:0]  w_starve_nxt;

    logic                  w_mem_en;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    logic                  r_rd_data_vld;
    logic                  r_dbg_rdata_vld;
    logic                  r_hold_req;
    logic [CNT_WIDTH-1:0]  r_starve_cnt;

    // The buffer can always drain unless a read takes the port while it is full.
    assign w_wr_rdy  = !(w_buf_vld && bus.rd_en);
    assign w_dbg_rdy = !bus.rd_en && !bus.wr_en && !w_buf_vld && !rst;

    // Port owner by fixed priority; nothing touches memory during reset so a pending write is dropped.
    always_comb begin
        w_owner = OWN_NONE;
        if (!rst) begin
            if (bus.rd_en) begin
                w_owner = OWN_RD;
            end else if (w_buf_vld) begin
                w_owner = OWN_BUF;
            end else if (bus.wr_en) begin
                w_owner = OWN_WR;
            end else if (bus.dbg_vld) begin
                w_owner = OWN_DBG;
            end
        end
    end

    assign w_dbg_grant  = (w_owner == OWN_DBG);
    assign w_buf_commit = (w_owner == OWN_BUF);
    // Park the write when a read holds the port, or behind an older buffered write to keep order.
    assign w_buf_load   = !rst && bus.wr_en && w_wr_rdy && (bus.rd_en || w_buf_vld);

    // Drive the memory port from the current owner.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (w_owner)
            OWN_RD: begin
                w_mem_en   = 1'b1;
                w_mem_addr = bus.rd_addr;
            end
            OWN_BUF: begin
                w_mem_en    = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = w_buf_addr;
                w_mem_wdata = w_buf_data;
            end
            OWN_WR: begin
                w_mem_en    = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = bus.wr_addr;
                w_mem_wdata = bus.wr_data;
            end
            OWN_DBG: begin
                w_mem_en    = 1'b1;
                w_mem_we    = bus.dbg_we;
                w_mem_addr  = bus.dbg_addr;
                w_mem_wdata = bus.dbg_wdata;
            end
            default: begin
                w_mem_en = 1'b0;
            end
        endcase
    end

    scratch_port_arbiter_wbuf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_buf_load),
        .i_commit    (w_buf_commit),
        .i_wr_addr   (bus.wr_addr),
        .i_wr_data   (bus.wr_data),
        .i_rd_en     (bus.rd_en),
        .i_rd_addr   (bus.rd_addr),
        .i_mem_rdata (bus.mem_rdata),
        .o_buf_vld   (w_buf_vld),
        .o_buf_addr  (w_buf_addr),
        .o_buf_data  (w_buf_data),
        .o_rd_data   (w_rd_data)
    );

    // Read-return qualifiers follow the access by one cycle, matching memory latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data_vld   <= 1'b0;
            r_dbg_rdata_vld <= 1'b0;
        end else begin
            r_rd_data_vld   <= bus.rd_en;
            r_dbg_rdata_vld <= w_dbg_grant && !bus.dbg_we;
        end
    end

    // Consecutive cycles the debug port has waited, saturating at the limit.
    assign w_dbg_wait   = bus.dbg_vld && !w_dbg_rdy;
    assign w_starve_nxt = !w_dbg_wait               ? '0 :
                          (r_starve_cnt == CNT_LIMIT) ? r_starve_cnt :
                          r_starve_cnt + 1'b1;

    // Starvation counter and sticky hold request; both drop once debug stops waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_hold_req   <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_hold_req   <= w_dbg_wait && (r_hold_req || (w_starve_nxt >= CNT_HOLD));
        end
    end

    assign bus.rd_data       = w_rd_data;
    assign bus.rd_data_vld   = r_rd_data_vld;
    assign bus.wr_rdy        = w_wr_rdy;
    assign bus.dbg_rdy       = w_dbg_rdy;
    assign bus.dbg_rdata     = bus.mem_rdata;
    assign bus.dbg_rdata_vld = r_dbg_rdata_vld;
    assign bus.hold_req      = r_hold_req;
    assign bus.mem_en        = w_mem_en;
    assign bus.mem_we        = w_mem_we;
    assign bus.mem_addr      = w_mem_addr;
    assign bus.mem_wdata     = w_mem_wdata;

endmodule

// File: tb/tb_scratch_port_arbiter.sv
// Randomized plus directed bench for scratch_port_arbiter against an architectural scratch model.
// Latency: checks read returns one cycle after the access.
// Backpressure: honours wr_rdy and hold_req like the pipeline controller would.
module tb_scratch_port_arbiter;
    import scratch_port_arbiter_pkg::*;

    localparam int AW     = 4;
    localparam int DW     = 32;
    localparam int LIMIT  = 8;
    localparam int NWORDS = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] old;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scratch_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    scratch_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIMIT),
        .CNT_WIDTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] seed_word(input int i);
        return 32'h9E37_79B9 * (i + 1);
    endfunction

    // Scratch memory: synchronous, 1-cycle read latency
    logic [DW-1:0] mem [NWORDS];
    bit            mem_init = 0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= seed_word(i);
            mem_init <= 1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    // Architectural model: arch[] holds every write in program order; pend holds writes not yet seen on the port
    logic [DW-1:0] arch [NWORDS];
    bit            arch_init = 0;
    wr_t           pend[$];
    int            n_checks = 0;
    int            n_errors = 0;
    bit            prev_rd = 0;
    logic [DW-1:0] prev_rd_exp = '0;
    bit            prev_dbg = 0;
    logic [DW-1:0] prev_dbg_exp = '0;
    int            waited = 0;
    bit            dbg_granted = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mem_expect(input bit en, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        chk("mem_en", DW'(bus.mem_en), DW'(en));
        if (en) begin
            chk("mem_we", DW'(bus.mem_we), DW'(we));
            chk("mem_addr", DW'(bus.mem_addr), DW'(addr));
            if (we) chk("mem_wdata", bus.mem_wdata, wdata);
        end
    endtask

    // Per-cycle checker and model update, away from the active edge
    always @(negedge clk) begin
        if (!arch_init) begin
            for (int i = 0; i < NWORDS; i++) arch[i] = seed_word(i);
            arch_init = 1;
        end
        if (rst) begin
            chk("rst_mem_en", DW'(bus.mem_en), '0);
            if (pend.size() != 0) arch[pend[0].addr] = pend[0].old;
            pend.delete();
            prev_rd = 0; prev_dbg = 0; waited = 0; dbg_granted = 0;
        end else begin
            bit  exp_wr_rdy, exp_dbg_rdy, grant, direct;
            wr_t e;
            chk("rd_data_vld", DW'(bus.rd_data_vld), DW'(prev_rd));
            if (prev_rd) chk("rd_data", bus.rd_data, prev_rd_exp);
            chk("dbg_rdata_vld", DW'(bus.dbg_rdata_vld), DW'(prev_dbg));
            if (prev_dbg) chk("dbg_rdata", bus.dbg_rdata, prev_dbg_exp);
            chk("hold_req", DW'(bus.hold_req), DW'(waited >= LIMIT - 1));

            exp_wr_rdy  = !(pend.size() > 0 && bus.rd_en);
            exp_dbg_rdy = !bus.rd_en && !bus.wr_en && pend.size() == 0;
            chk("wr_rdy", DW'(bus.wr_rdy), DW'(exp_wr_rdy));
            chk("dbg_rdy", DW'(bus.dbg_rdy), DW'(exp_dbg_rdy));
            grant  = bus.dbg_vld && exp_dbg_rdy;
            direct = 0;

            if (bus.rd_en) begin
                mem_expect(1, 0, bus.rd_addr, '0);
            end else if (pend.size() > 0) begin
                mem_expect(1, 1, pend[0].addr, pend[0].data);
                void'(pend.pop_front());
            end else if (bus.wr_en) begin
                mem_expect(1, 1, bus.wr_addr, bus.wr_data);
                direct = 1;
            end else if (grant) begin
                mem_expect(1, bus.dbg_we, bus.dbg_addr, bus.dbg_wdata);
            end else begin
                mem_expect(0, 0, '0, '0);
            end

            // Reads see only older writes; the same-cycle write lands afterwards
            prev_rd = bus.rd_en;
            if (bus.rd_en) prev_rd_exp = arch[bus.rd_addr];
            if (bus.wr_en) begin
                e.addr = bus.wr_addr; e.data = bus.wr_data; e.old = arch[bus.wr_addr];
                arch[bus.wr_addr] = bus.wr_data;
                if (!direct) pend.push_back(e);
            end
            prev_dbg = grant && !bus.dbg_we;
            if (grant) begin
                if (bus.dbg_we) arch[bus.dbg_addr] = bus.dbg_wdata;
                else            prev_dbg_exp = arch[bus.dbg_addr];
            end
            waited      = (bus.dbg_vld && !exp_dbg_rdy) ? waited + 1 : 0;
            dbg_granted = grant;
        end
    end

    task automatic drive(input bit rd, input logic [AW-1:0] ra,
                         input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit dv, input bit dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        bus.rd_en = rd;   bus.rd_addr = ra;
        bus.wr_en = wr;   bus.wr_addr = wa;  bus.wr_data = wd;
        bus.dbg_vld = dv; bus.dbg_we = dwe;  bus.dbg_addr = da; bus.dbg_wdata = dwd;
    endtask

    task automatic cyc(input bit rd, input logic [AW-1:0] ra,
                       input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit dv, input bit dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        @(posedge clk); #1;
        drive(rd, ra, wr, wa, wd, dv, dwe, da, dwd);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, '0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        drive(0, '0, 0, '0, '0, 0, 0, '0, '0);
        @(posedge clk); #1;
        rst = 0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, NWORDS - 1));
    endfunction

    initial begin
        bit            dv = 0;
        bit            dwe = 0;
        logic [AW-1:0] da = '0;
        logic [DW-1:0] dwd = '0;

        drive(0, '0, 0, '0, '0, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Direct write then back-to-back read of the same word
        cyc(0, 4'd0, 1, 4'd3, 32'hDEAD_BEEF, 0, 0, '0, '0);
        cyc(1, 4'd3, 0, '0, '0, 0, 0, '0, '0);
        idle(2);

        // Collision: memory holds 0x22, read and write of addr 5 in the same cycle
        cyc(0, '0, 1, 4'd5, 32'h22, 0, 0, '0, '0);
        cyc(1, 4'd5, 1, 4'd5, 32'h11, 0, 0, '0, '0);
        idle(1);
        cyc(1, 4'd5, 0, '0, '0, 0, 0, '0, '0);
        idle(1);

        // Forward from the buffer while reads keep it from draining
        cyc(1, 4'd1, 1, 4'd7, 32'hA5A5_A5A5, 0, 0, '0, '0);
        cyc(1, 4'd7, 0, '0, '0, 0, 0, '0, '0);
        cyc(1, 4'd7, 0, '0, '0, 0, 0, '0, '0);
        idle(2);

        // Ordering: buffered write to addr 2 followed by a newer write to addr 2
        cyc(1, 4'd0, 1, 4'd2, 32'd1, 0, 0, '0, '0);
        cyc(0, '0, 1, 4'd2, 32'd2, 0, 0, '0, '0);
        idle(1);
        cyc(1, 4'd2, 0, '0, '0, 0, 0, '0, '0);
        idle(1);

        // Starvation: debug read of addr 9 under continuous reads
        for (int i = 0; i < 10; i++) cyc(1, AW'(i), 0, '0, '0, 1, 0, 4'd9, '0);
        cyc(0, '0, 0, '0, '0, 1, 0, 4'd9, '0);
        idle(3);

        // Reset with a write parked in the buffer loses that write
        cyc(1, 4'd0, 1, 4'd4, 32'h0000_1234, 0, 0, '0, '0);
        do_reset();
        cyc(1, 4'd4, 0, '0, '0, 0, 0, '0, '0);
        idle(2);

        // Randomized traffic obeying wr_rdy, hold_req and valid/ready stability
        for (int i = 0; i < 3000; i++) begin
            bit            rd, wr, block;
            logic [AW-1:0] ra, wa;
            if (i % 1000 == 999) begin
                do_reset();
                dv = 0;
            end
            @(posedge clk); #1;
            block = (waited >= LIMIT - 1);
            if (dv && dbg_granted) dv = 0;
            if (!dv && $urandom_range(0, 3) == 0) begin
                dv  = 1;
                dwe = 1'($urandom_range(0, 1));
                da  = rand_addr();
                dwd = $urandom();
            end
            rd = !block && ($urandom_range(0, 1) == 1);
            wr = !block && !(rd && pend.size() > 0) && ($urandom_range(0, 9) < 4);
            ra = rand_addr();
            wa = rand_addr();
            drive(rd, ra, wr, wa, $urandom(), dv, dwe, da, dwd);
        end

        // Drain and compare the whole scratch file with the model
        idle(4);
        @(negedge clk);
        for (int i = 0; i < NWORDS; i++) chk($sformatf("final_m%0d", i), mem[i], arch[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
